// File: rtl/cnt_cmd_ctrl.sv
// Pushbutton front end and run-control FSM for the up/down counter.
// Each button is synchronized and debounced; the FSM drives act/up_dwn_n and latches overflow as a halt.

module cnt_cmd_btn #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);
    logic [1:0] sync;
    logic       level;
    logic [7:0] cnt;

    // press is raised on the same edge the debounced level rises, so it is one cycle wide
    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= '0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            press <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == 8'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync[1];
                cnt   <= '0;
                press <= sync[1];
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end
endmodule

module cnt_cmd_ctrl #(
    parameter int          DEBOUNCE_CYCLES = 4,
    parameter logic [15:0] MAX_RUN         = 16'd0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_dn,
    input  logic btn_hold,
    input  logic ovflw_in,
    output logic act,
    output logic up_dwn_n,
    output logic halted
);
    localparam int NUM_BTN = 3;

    typedef enum logic [1:0] {IDLE, RUN_UP, RUN_DN, HALT} state_t;

    logic [NUM_BTN-1:0] btn_raw, btn_press;
    logic               up_ev, dn_ev, hold_ev;
    state_t             state, state_nxt;
    logic [15:0]        run_cnt;
    logic               run_exp, run_nxt, entering;

    assign btn_raw = {btn_hold, btn_dn, btn_up};

    generate
        for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
            cnt_cmd_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
                .clk  (clk),
                .rst  (rst),
                .raw  (btn_raw[i]),
                .press(btn_press[i])
            );
        end
    endgenerate

    assign up_ev   = btn_press[0];
    assign dn_ev   = btn_press[1];
    assign hold_ev = btn_press[2];

    assign run_exp = (MAX_RUN != 16'd0) && (run_cnt == MAX_RUN - 16'd1);

    always_comb begin
        state_nxt = state;
        if (ovflw_in) begin
            state_nxt = HALT;
        end else begin
            case (state)
                IDLE: begin
                    if (up_ev && !dn_ev)      state_nxt = RUN_UP;
                    else if (dn_ev && !up_ev) state_nxt = RUN_DN;
                end
                RUN_UP: begin
                    if (hold_ev || run_exp)   state_nxt = IDLE;
                    else if (dn_ev && !up_ev) state_nxt = RUN_DN;
                end
                RUN_DN: begin
                    if (hold_ev || run_exp)   state_nxt = IDLE;
                    else if (up_ev && !dn_ev) state_nxt = RUN_UP;
                end
                HALT:    state_nxt = HALT;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign run_nxt  = (state_nxt == RUN_UP) || (state_nxt == RUN_DN);
    assign entering = run_nxt && (state_nxt != state);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            act      <= 1'b0;
            up_dwn_n <= 1'b1;
            halted   <= 1'b0;
            run_cnt  <= '0;
        end else begin
            state  <= state_nxt;
            act    <= run_nxt;
            halted <= (state_nxt == HALT);
            if (entering) begin
                up_dwn_n <= (state_nxt == RUN_UP);
                run_cnt  <= '0;
            end else if (act && run_cnt != 16'hFFFF) begin
                run_cnt <= run_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_cnt_cmd_ctrl.sv
// Directed bench for cnt_cmd_ctrl: a step table for the default build, plus hand sequences
// against a MAX_RUN=10 build for auto-stop corner cases.

module tb_cnt_cmd_ctrl;
    logic clk = 1'b0;
    logic rst, btn_up, btn_dn, btn_hold, ovflw_in;
    logic act0, dir0, halt0;
    logic act1, dir1, halt1;
    int   tests = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    cnt_cmd_ctrl #(.DEBOUNCE_CYCLES(4), .MAX_RUN(16'd0)) dut0 (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn), .btn_hold(btn_hold),
        .ovflw_in(ovflw_in), .act(act0), .up_dwn_n(dir0), .halted(halt0)
    );

    cnt_cmd_ctrl #(.DEBOUNCE_CYCLES(4), .MAX_RUN(16'd10)) dut1 (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn), .btn_hold(btn_hold),
        .ovflw_in(ovflw_in), .act(act1), .up_dwn_n(dir1), .halted(halt1)
    );

    typedef struct {
        string name;
        logic  r, u, d, h, o;
        int    n;
        logic  every;
        logic  ea, ed, eh;
    } step_t;

    step_t steps[$];

    function automatic step_t mk(string name, logic r, logic u, logic d, logic h, logic o,
                                 int n, logic every, logic ea, logic ed, logic eh);
        step_t s;
        s.name = name; s.r = r; s.u = u; s.d = d; s.h = h; s.o = o;
        s.n = n; s.every = every; s.ea = ea; s.ed = ed; s.eh = eh;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic ga, logic gd, logic gh, logic ea, logic ed, logic eh);
        tests++;
        if ({ga, gd, gh} !== {ea, ed, eh}) begin
            failed++;
            $display("FAIL %s: got act=%b dir=%b halted=%b, want act=%b dir=%b halted=%b",
                     name, ga, gd, gh, ea, ed, eh);
        end
    endtask

    task automatic chk_int(string name, int got, int exp);
        tests++;
        if (got != exp) begin
            failed++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    task automatic drive(logic r, logic u, logic d, logic h, logic o);
        rst = r; btn_up = u; btn_dn = d; btn_hold = h; ovflw_in = o;
    endtask

    initial begin
        int cnt;
        drive(1, 0, 0, 0, 0);

        //                 name            rst up dn ho ov  n ev  act dir halt
        steps.push_back(mk("rst_a",         1, 1, 0, 0, 0,  1, 1,  0, 1, 0));
        steps.push_back(mk("rst_b",         1, 0, 1, 1, 0,  1, 1,  0, 1, 0));
        steps.push_back(mk("post_rst",      0, 0, 0, 0, 0,  8, 1,  0, 1, 0));
        steps.push_back(mk("glitch3",       0, 1, 0, 0, 0,  3, 1,  0, 1, 0));
        steps.push_back(mk("glitch_after",  0, 0, 0, 0, 0, 10, 1,  0, 1, 0));
        steps.push_back(mk("up_lat6",       0, 1, 0, 0, 0,  6, 1,  0, 1, 0));
        steps.push_back(mk("up_lat7",       0, 1, 0, 0, 0,  1, 0,  1, 1, 0));
        steps.push_back(mk("up_held",       0, 1, 0, 0, 0,  3, 1,  1, 1, 0));
        steps.push_back(mk("up_release",    0, 0, 0, 0, 0,  8, 1,  1, 1, 0));
        steps.push_back(mk("swap_pre",      0, 0, 1, 0, 0,  6, 1,  1, 1, 0));
        steps.push_back(mk("swap_dn",       0, 0, 1, 0, 0,  1, 0,  1, 0, 0));
        steps.push_back(mk("dn_release",    0, 0, 0, 0, 0,  8, 1,  1, 0, 0));
        steps.push_back(mk("run_up_dn",     0, 1, 1, 0, 0, 10, 1,  1, 0, 0));
        steps.push_back(mk("run_up_dn_rel", 0, 0, 0, 0, 0,  8, 1,  1, 0, 0));
        steps.push_back(mk("hold_pre",      0, 0, 0, 1, 0,  6, 1,  1, 0, 0));
        steps.push_back(mk("hold_stop",     0, 0, 0, 1, 0,  1, 0,  0, 0, 0));
        steps.push_back(mk("hold_rel",      0, 0, 0, 0, 0,  8, 1,  0, 0, 0));
        steps.push_back(mk("idle_hold",     0, 0, 0, 1, 0, 10, 1,  0, 0, 0));
        steps.push_back(mk("idle_hold_rel", 0, 0, 0, 0, 0,  8, 1,  0, 0, 0));
        steps.push_back(mk("idle_up_dn",    0, 1, 1, 0, 0, 10, 1,  0, 0, 0));
        steps.push_back(mk("idle_ud_rel",   0, 0, 0, 0, 0,  8, 1,  0, 0, 0));
        steps.push_back(mk("up_again",      0, 1, 0, 0, 0,  7, 0,  1, 1, 0));
        steps.push_back(mk("up_again_rel",  0, 0, 0, 0, 0,  8, 1,  1, 1, 0));
        steps.push_back(mk("ovf_pulse",     0, 0, 0, 0, 1,  1, 0,  0, 1, 1));
        steps.push_back(mk("halt_up",       0, 1, 0, 0, 0, 10, 1,  0, 1, 1));
        steps.push_back(mk("halt_up_rel",   0, 0, 0, 0, 0,  8, 1,  0, 1, 1));
        steps.push_back(mk("halt_dn",       0, 0, 1, 0, 0, 10, 1,  0, 1, 1));
        steps.push_back(mk("halt_hold",     0, 0, 0, 1, 0, 10, 1,  0, 1, 1));
        steps.push_back(mk("halt_rst",      1, 0, 0, 0, 0,  1, 0,  0, 1, 0));
        steps.push_back(mk("halt_idle",     0, 0, 0, 0, 0,  8, 1,  0, 1, 0));
        steps.push_back(mk("oh_up",         0, 1, 0, 0, 0,  7, 0,  1, 1, 0));
        steps.push_back(mk("oh_up_rel",     0, 0, 0, 0, 0,  8, 1,  1, 1, 0));
        steps.push_back(mk("oh_hold_pre",   0, 0, 0, 1, 0,  6, 1,  1, 1, 0));
        steps.push_back(mk("ovf_and_hold",  0, 0, 0, 1, 1,  1, 0,  0, 1, 1));
        steps.push_back(mk("ovf_hold_after",0, 0, 0, 0, 0,  5, 1,  0, 1, 1));
        steps.push_back(mk("final_rst",     1, 0, 0, 0, 0,  1, 0,  0, 1, 0));

        foreach (steps[i]) begin
            drive(steps[i].r, steps[i].u, steps[i].d, steps[i].h, steps[i].o);
            for (int c = 0; c < steps[i].n; c++) begin
                tick();
                if (steps[i].every || c == steps[i].n - 1)
                    chk(steps[i].name, act0, dir0, halt0, steps[i].ea, steps[i].ed, steps[i].eh);
            end
        end

        // Auto-stop: one clean up press keeps act high for exactly MAX_RUN cycles.
        drive(1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        repeat (4) tick();
        btn_up = 1'b1;
        cnt = 0;
        for (int c = 0; c < 30; c++) begin
            if (c == 10) btn_up = 1'b0;
            tick();
            if (act1) cnt++;
        end
        chk_int("autostop_cycles", cnt, 10);
        chk("autostop_end", act1, dir1, halt1, 1'b0, 1'b1, 1'b0);
        chk("no_autostop_dut0", act0, dir0, halt0, 1'b1, 1'b1, 1'b0);

        // Hold press landing on the same edge as run expiry.
        drive(1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        repeat (4) tick();
        btn_up = 1'b1;
        repeat (10) tick();
        btn_up = 1'b0;
        btn_hold = 1'b1;
        repeat (6) tick();
        chk("exp_hold_pre", act1, dir1, halt1, 1'b1, 1'b1, 1'b0);
        tick();
        chk("exp_hold_edge", act1, dir1, halt1, 1'b0, 1'b1, 1'b0);
        chk("exp_hold_dut0", act0, dir0, halt0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("exp_hold_after", act1, dir1, halt1, 1'b0, 1'b1, 1'b0);
        btn_hold = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
